instr_mem_arbiter: RTL



---
 rtl/instr_mem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter
// Shares one single-port synchronous instruction RAM between the CoreABC
// fetch path and an APB slave. The APB slave loads or reads back instruction
// words through a byte-lane staging register. Fetches take priority; an APB
// COMMIT/READBACK is held with PREADY low until the RAM is free.
module instr_mem_arbiter #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int ICWIDTH = 8,
  parameter int IWWIDTH = 58
) (
  input  logic               CLK,
  input  logic               RST,
  // CoreABC fetch path
  input  logic               START,
  input  logic [ICWIDTH-1:0] ADDRESS,
  output logic               STALL,
  output logic [IWWIDTH-1:0] INSTRUCTION,
  // APB slave
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [AWIDTH-1:0]  PADDR,
  input  logic [DWIDTH-1:0]  PWDATA,
  output logic [DWIDTH-1:0]  PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  // Instruction RAM
  output logic [ICWIDTH-1:0] RAM_ADDR,
  output logic               RAM_WE,
  output logic               RAM_RE,
  output logic [IWWIDTH-1:0] RAM_WDATA,
  input  logic [IWWIDTH-1:0] RAM_RDATA
);

  localparam int NCHUNK = (IWWIDTH + DWIDTH - 1) / DWIDTH;
  localparam int SWIDTH = NCHUNK * DWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR,
    S_RD_ISSUE,
    S_RD_CAP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IWWIDTH-1:0]   r_staging;
  logic [IWWIDTH-1:0]   r_instr;
  logic [ICWIDTH-1:0]   r_addr;
  logic [ICWIDTH-1:0]   r_pend_addr;
  logic                 r_pend_fetch;

  logic                 w_acc;
  logic                 w_ctrl_sel;
  logic                 w_addr_sel;
  logic                 w_err_sel;
  logic                 w_chunk_sel;
  logic                 w_commit;
  logic                 w_readback;
  logic                 w_rd_busy;
  logic                 w_stage_we;
  logic                 w_fetch_go;
  logic [ICWIDTH-1:0]   w_fetch_addr;
  logic [SWIDTH-1:0]    w_stage_ext;
  logic [SWIDTH-1:0]    w_stage_wr;
  logic [DWIDTH-1:0]    w_chunk_rd;

  // APB address decode; only the access phase carries side effects
  assign w_acc       = PSEL & PENABLE;
  assign w_ctrl_sel  = (PADDR == AWIDTH'(0));
  assign w_addr_sel  = (PADDR == AWIDTH'(1));
  assign w_err_sel   = (PADDR >= AWIDTH'(2 + NCHUNK));
  assign w_chunk_sel = ~w_ctrl_sel & ~w_addr_sel & ~w_err_sel;

  // COMMIT wins when both command bits are set
  assign w_commit    = w_acc & PWRITE & w_ctrl_sel & PWDATA[0];
  assign w_readback  = w_acc & PWRITE & w_ctrl_sel & PWDATA[1] & ~PWDATA[0];

  // Readback owns the staging register until the captured word lands
  assign w_rd_busy   = (r_state == S_RD_ISSUE) | (r_state == S_RD_CAP);
  assign w_stage_we  = w_acc & PWRITE & w_chunk_sel & ~w_rd_busy;

  // A queued fetch is served before a fresh START on return to IDLE
  assign w_fetch_go   = (r_state == S_IDLE) & (r_pend_fetch | START);
  assign w_fetch_addr = r_pend_fetch ? r_pend_addr : ADDRESS;

  // Pad bits above IWWIDTH are zero, so the top chunk reads back truncated
  assign w_stage_ext = SWIDTH'(r_staging);
  assign RAM_WDATA   = r_staging;
  assign INSTRUCTION = r_instr;

  // Chunk read mux and chunk write merge into the padded staging word
  always_comb begin
    w_chunk_rd = '0;
    w_stage_wr = w_stage_ext;
    for (int k = 0; k < NCHUNK; k++) begin
      if (PADDR == AWIDTH'(k + 2)) begin
        w_chunk_rd                       = w_stage_ext[k*DWIDTH +: DWIDTH];
        w_stage_wr[k*DWIDTH +: DWIDTH]   = PWDATA;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, RAM strobes, fetch stall and APB handshake
  always_comb begin
    w_state_nxt = r_state;
    RAM_RE      = 1'b0;
    RAM_WE      = 1'b0;
    RAM_ADDR    = r_addr;
    STALL       = r_pend_fetch | (START & (r_state != S_IDLE));
    PREADY      = 1'b1;
    PSLVERR     = 1'b0;
    PRDATA      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_fetch_go) begin
          RAM_RE      = 1'b1;
          RAM_ADDR    = w_fetch_addr;
          STALL       = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_commit) begin
          w_state_nxt = S_WR;
        end else if (w_readback) begin
          w_state_nxt = S_RD_ISSUE;
        end
      end
      S_FETCH: begin
        STALL = 1'b1;
        // A command held off by this fetch goes straight to the RAM
        if (START | r_pend_fetch) w_state_nxt = S_IDLE;
        else if (w_commit)        w_state_nxt = S_WR;
        else if (w_readback)      w_state_nxt = S_RD_ISSUE;
        else                      w_state_nxt = S_IDLE;
      end
      S_WR: begin
        RAM_WE      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RD_ISSUE: begin
        RAM_RE      = 1'b1;
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_acc) begin
      if (w_err_sel) begin
        PSLVERR = 1'b1;
      end else if (w_commit | w_readback) begin
        PREADY = (r_state == S_WR) | (r_state == S_RD_CAP);
      end else if (w_stage_we == 1'b0 && PWRITE && w_chunk_sel) begin
        PREADY = 1'b0;
      end
    end

    if (PSEL & ~PWRITE) begin
      if (w_ctrl_sel)       PRDATA = DWIDTH'(r_state != S_IDLE);
      else if (w_addr_sel)  PRDATA = DWIDTH'(r_addr);
      else if (w_chunk_sel) PRDATA = w_chunk_rd;
    end
  end

  // Fetch result capture, one cycle after the RAM read strobe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     r_instr <= '0;
    else if (r_state == S_FETCH) r_instr <= RAM_RDATA;
  end

  // Staging word: readback capture has priority over APB chunk writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      r_staging <= '0;
    else if (r_state == S_RD_CAP) r_staging <= RAM_RDATA;
    else if (w_stage_we)          r_staging <= w_stage_wr[IWWIDTH-1:0];
  end

  // APB-loaded RAM address register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                           r_addr <= '0;
    else if (w_acc & PWRITE & w_addr_sel) r_addr <= PWDATA[ICWIDTH-1:0];
  end

  // Fetch arriving while the RAM is busy is queued with its address
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend_fetch <= 1'b0;
      r_pend_addr  <= '0;
    end else if (START & (r_state != S_IDLE)) begin
      r_pend_fetch <= 1'b1;
      r_pend_addr  <= ADDRESS;
    end else if (w_fetch_go) begin
      r_pend_fetch <= 1'b0;
    end
  end

endmodule
